// File: rtl/channel_mod_counter.sv
// Multi-channel modulo-MOD_VALUE up/down counters with terminal-count pulse and sticky wrap flags.
// Optional count snapshot enabled by defining CHANNEL_MOD_COUNTER_SNAPSHOT_EN.
module channel_mod_counter #(
   parameter int WIDTH     = 4,
   parameter int NUM_CH    = 2,
   parameter int MOD_VALUE = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         en,
   input  logic [NUM_CH-1:0]         dir,
   input  logic [NUM_CH-1:0]         load,
   input  logic [NUM_CH*WIDTH-1:0]   load_val,
   input  logic                      clr_sticky,
   input  logic                      snap_req,
   output logic [NUM_CH*WIDTH-1:0]   count_out,
   output logic [NUM_CH-1:0]         tc,
   output logic [NUM_CH-1:0]         wrap_sticky,
   output logic [NUM_CH*WIDTH-1:0]   snap_out,
   output logic                      snap_valid
);

   // Top count value; fits WIDTH bits even when MOD_VALUE == 2**WIDTH.
   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD_VALUE - 1);

   logic [NUM_CH-1:0][WIDTH-1:0] load_val_ch;
   logic [NUM_CH-1:0][WIDTH-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]            tc_q, tc_d;
   logic [NUM_CH-1:0]            sticky_q, sticky_d;

   assign load_val_ch = load_val;

   always_comb begin
      cnt_d    = cnt_q;
      tc_d     = '0;
      sticky_d = sticky_q & ~{NUM_CH{clr_sticky}};
      for (int i = 0; i < NUM_CH; i++) begin
         if (load[i]) begin
            cnt_d[i] = (load_val_ch[i] > CNT_MAX) ? CNT_MAX : load_val_ch[i];
         end else if (en[i]) begin
            if (dir[i]) begin
               if (cnt_q[i] == CNT_MAX) begin
                  cnt_d[i] = '0;
                  tc_d[i]  = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + WIDTH'(1);
               end
            end else begin
               if (cnt_q[i] == '0) begin
                  cnt_d[i] = CNT_MAX;
                  tc_d[i]  = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] - WIDTH'(1);
               end
            end
         end
      end
      // A wrap in the same cycle as a clear wins, so the flag is OR-ed in last.
      sticky_d = sticky_d | tc_d;
      if (!rst) begin
         cnt_d    = '0;
         tc_d     = '0;
         sticky_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q    <= cnt_d;
      tc_q     <= tc_d;
      sticky_q <= sticky_d;
   end

   assign count_out   = cnt_q;
   assign tc          = tc_q;
   assign wrap_sticky = sticky_q;

`ifdef CHANNEL_MOD_COUNTER_SNAPSHOT_EN
   logic [NUM_CH*WIDTH-1:0] snap_q, snap_d;
   logic                    snap_vld_q, snap_vld_d;

   always_comb begin
      snap_d     = snap_req ? cnt_q : snap_q;
      snap_vld_d = snap_req;
      if (!rst) begin
         snap_d     = '0;
         snap_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
   end

   assign snap_out   = snap_q;
   assign snap_valid = snap_vld_q;
`else
   logic snap_req_unused;
   assign snap_req_unused = snap_req;
   assign snap_out        = '0;
   assign snap_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_channel_mod_counter.sv
// Directed plus randomized bench for channel_mod_counter against an arithmetic reference model.
module tb_channel_mod_counter;
   localparam int W   = 4;
   localparam int NCH = 2;
   localparam int MOD = 10;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH-1:0]       en, dir, load;
   logic [NCH*W-1:0]     load_val;
   logic                 clr_sticky, snap_req;
   logic [NCH*W-1:0]     count_out, snap_out;
   logic [NCH-1:0]       tc, wrap_sticky;
   logic                 snap_valid;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   int m_cnt    [NCH];
   bit m_tc     [NCH];
   bit m_sticky [NCH];
   int m_snap   [NCH];
   bit m_snap_vld;

   channel_mod_counter #(.WIDTH(W), .NUM_CH(NCH), .MOD_VALUE(MOD)) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .clr_sticky(clr_sticky), .snap_req(snap_req), .count_out(count_out), .tc(tc),
      .wrap_sticky(wrap_sticky), .snap_out(snap_out), .snap_valid(snap_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int old[NCH];
      for (int c = 0; c < NCH; c++) old[c] = m_cnt[c];
      if (!rst) begin
         for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_tc[c] = 0; m_sticky[c] = 0; m_snap[c] = 0;
         end
         m_snap_vld = 0;
         return;
      end
      for (int c = 0; c < NCH; c++) begin
         int lv, raw;
         bit wrapped;
         lv = int'(load_val[c*W +: W]);
         wrapped = 0;
         if (load[c]) begin
            m_cnt[c] = (lv >= MOD) ? MOD - 1 : lv;
         end else if (en[c]) begin
            raw = dir[c] ? old[c] + 1 : old[c] - 1;
            wrapped = (raw < 0) || (raw >= MOD);
            m_cnt[c] = (raw + MOD) % MOD;
         end
         m_tc[c] = wrapped;
         m_sticky[c] = wrapped || (m_sticky[c] && !clr_sticky);
      end
`ifdef CHANNEL_MOD_COUNTER_SNAPSHOT_EN
      if (snap_req) for (int c = 0; c < NCH; c++) m_snap[c] = old[c];
      m_snap_vld = snap_req;
`endif
   endtask

   task automatic compare_all();
      logic [NCH*W-1:0] e_cnt, e_snap;
      logic [NCH-1:0]   e_tc, e_st;
      for (int c = 0; c < NCH; c++) begin
         e_cnt[c*W +: W] = W'(m_cnt[c]);
         e_snap[c*W +: W] = W'(m_snap[c]);
         e_tc[c] = m_tc[c];
         e_st[c] = m_sticky[c];
      end
      check("count_out", 32'(count_out), 32'(e_cnt));
      check("tc", 32'(tc), 32'(e_tc));
      check("wrap_sticky", 32'(wrap_sticky), 32'(e_st));
      check("snap_out", 32'(snap_out), 32'(e_snap));
      check("snap_valid", 32'(snap_valid), 32'(m_snap_vld));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   initial begin
      rst = 1'b0; en = '0; dir = '0; load = '0; load_val = '0;
      clr_sticky = 1'b0; snap_req = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c] = 0; m_tc[c] = 0; m_sticky[c] = 0; m_snap[c] = 0;
      end
      m_snap_vld = 0;

      // Reset state
      tick(); tick();
      check("reset_count", 32'(count_out), 32'h0);
      rst = 1'b1;

      // ch0 counting up through a wrap
      en = 2'b01; dir = 2'b01;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("up_seq_ch0", 32'(count_out[3:0]), 32'((i + 1) % MOD));
         check("up_seq_tc0", 32'(tc[0]), 32'(i == 9));
      end
      check("sticky_after_wrap", 32'(wrap_sticky[0]), 32'h1);

      // ch1 counting down from 0, ch0 held
      en = 2'b10; dir = 2'b00;
      tick();
      check("down_wrap_ch1", 32'(count_out[7:4]), 32'd9);
      check("down_wrap_tc1", 32'(tc[1]), 32'h1);
      tick(); tick();
      check("down_ch1_7", 32'(count_out[7:4]), 32'd7);
      check("hold_ch0", 32'(count_out[3:0]), 32'd2);

      // Load clamps and overrides enable
      en = 2'b01; dir = 2'b01; load = 2'b01; load_val = 8'h0D;
      tick();
      check("load_clamp", 32'(count_out[3:0]), 32'd9);
      check("load_no_tc", 32'(tc[0]), 32'h0);
      load_val = 8'h05;
      tick();
      check("load_5", 32'(count_out[3:0]), 32'd5);

      // Wrap coincident with clr_sticky keeps the flag; clr alone clears
      load_val = 8'h09; en = 2'b00;
      tick();
      load = '0; en = 2'b01; clr_sticky = 1'b1;
      tick();
      check("wrap_vs_clr", 32'(wrap_sticky[0]), 32'h1);
      en = '0;
      tick();
      check("clr_alone", 32'(wrap_sticky), 32'h0);
      clr_sticky = 1'b0;

      // Reset mid-count overrides everything
      load = 2'b01; load_val = 8'h07;
      tick();
      load = '0; en = 2'b01; dir = 2'b01; snap_req = 1'b1; rst = 1'b0;
      tick();
      check("rst_count", 32'(count_out), 32'h0);
      check("rst_snapv", 32'(snap_valid), 32'h0);
      rst = 1'b1; snap_req = 1'b0;
      tick();
      check("resume_1", 32'(count_out[3:0]), 32'd1);
      tick();
      check("resume_2", 32'(count_out[3:0]), 32'd2);

      // Snapshot of {6,4}
      en = '0; load = 2'b11; load_val = 8'h64;
      tick();
      load = '0; snap_req = 1'b1;
      tick();
`ifdef CHANNEL_MOD_COUNTER_SNAPSHOT_EN
      check("snap_val", 32'(snap_out), 32'h64);
      check("snap_pulse", 32'(snap_valid), 32'h1);
`else
      check("snap_off_val", 32'(snap_out), 32'h0);
      check("snap_off_pulse", 32'(snap_valid), 32'h0);
`endif
      snap_req = 1'b0;
      tick();
      check("snap_pulse_end", 32'(snap_valid), 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         en         = NCH'($urandom);
         dir        = NCH'($urandom);
         load       = NCH'($urandom_range(0, 7) == 0 ? $urandom : 0);
         load_val   = (NCH*W)'($urandom);
         clr_sticky = ($urandom_range(0, 9) == 0);
         snap_req   = ($urandom_range(0, 3) == 0);
         rst        = ($urandom_range(0, 49) != 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
